// File: rtl/sync_decoder.sv
// -----------------------------------------------------------------------------
// sync_decoder
//
// Receive-side partner of the composite line-timing generator. It slices
// digitized composite video and qualifies Hsync tips by width and line period.
// A flywheel line counter tracks the line. Once locked, the block reports the
// same porch/Hsync/colourBurst/activeVideo phase encoding as the generator.
//
// Ports
//   clk         system clock, one sample per clock
//   reset       asynchronous, active-low reset
//   sample      digitized composite video from the ADC capture register
//   state       line phase: 0=Hsync 1=porch 2=colourBurst 3=activeVideo
//                 (forced to porch while unlocked)
//   locked      high while the acquisition FSM is in LOCKED
//   line_start  1-clk pulse when the line counter wraps to 0 while locked
//   sync_ok     1-clk pulse for every width-qualified sync tip
// -----------------------------------------------------------------------------
module sync_decoder #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SYNC_LEVEL = 40,
  parameter int unsigned HSYNC_MIN  = 200,
  parameter int unsigned HSYNC_MAX  = 270,
  parameter int unsigned HSYNC_END  = 310,
  parameter int unsigned LINE_LEN   = 3176,
  parameter int unsigned PERIOD_TOL = 8,
  parameter int unsigned LOCK_LINES = 4,
  parameter int unsigned MISS_LINES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  output logic [2:0]        state,
  output logic              locked,
  output logic              line_start,
  output logic              sync_ok
);

  localparam logic [DATA_W-1:0] SyncLevel = DATA_W'(SYNC_LEVEL);
  localparam logic [11:0]       HsyncMin  = 12'(HSYNC_MIN);
  localparam logic [11:0]       HsyncMax  = 12'(HSYNC_MAX);
  localparam logic [11:0]       SyncLoad  = 12'(HSYNC_END + 1);
  localparam logic [11:0]       LineLast  = 12'(LINE_LEN - 1);
  localparam logic [11:0]       PerLo     = 12'(LINE_LEN - PERIOD_TOL);
  localparam logic [11:0]       PerHi     = 12'(LINE_LEN + PERIOD_TOL);
  localparam logic [11:0]       CntMax    = 12'hfff;
  localparam logic [3:0]        LockLines = 4'(LOCK_LINES);
  localparam logic [3:0]        MissLines = 4'(MISS_LINES);

  // Line-phase boundaries, matching the generator's timing.
  localparam logic [11:0] EndPorch0 = 12'd75;
  localparam logic [11:0] EndHsync  = 12'd310;
  localparam logic [11:0] EndPorch1 = 12'd340;
  localparam logic [11:0] EndBurst  = 12'd465;
  localparam logic [11:0] EndPorch2 = 12'd545;

  localparam logic [2:0] PhHsync  = 3'd0;
  localparam logic [2:0] PhPorch  = 3'd1;
  localparam logic [2:0] PhBurst  = 3'd2;
  localparam logic [2:0] PhActive = 3'd3;

  typedef enum logic [1:0] {
    StSearch,
    StAcquire,
    StLocked
  } fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic        sync_low_q, sync_low_d;
  logic [11:0] pw_q, pw_d;
  logic [11:0] per_q, per_d;
  logic [11:0] count_q, count_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  miss_q, miss_d;
  logic        seen_q, seen_d;
  logic        sync_ok_q, sync_ok_d;
  logic        locked_q, locked_d;
  logic        line_start_q, line_start_d;
  logic [2:0]  state_q, state_d;

  logic sync_fall;
  logic per_good;
  logic good_sync;
  logic align;
  logic wrap;

  function automatic logic [2:0] decode_phase(input logic [11:0] c);
    logic [2:0] ph;
    if (c < EndPorch0) begin
      ph = PhPorch;
    end else if (c < EndHsync) begin
      ph = PhHsync;
    end else if (c < EndPorch1) begin
      ph = PhPorch;
    end else if (c < EndBurst) begin
      ph = PhBurst;
    end else if (c < EndPorch2) begin
      ph = PhPorch;
    end else begin
      ph = PhActive;
    end
    return ph;
  endfunction

  // Slicer, width counter and width qualification.
  always_comb begin
    sync_low_d = (sample < SyncLevel);

    if (sync_low_q) begin
      pw_d = (pw_q == CntMax) ? pw_q : pw_q + 12'd1;
    end else begin
      pw_d = 12'd0;
    end

    // pw only clears one clock after sync_low drops, so a non-zero pw with
    // sync_low low marks the trailing edge and still holds the full width.
    sync_fall = !sync_low_q && (pw_q != 12'd0);
    sync_ok_d = sync_fall && (pw_q >= HsyncMin) && (pw_q <= HsyncMax);
  end

  // Period measurement, flywheel line counter and acquisition FSM.
  always_comb begin
    if (sync_ok_q) begin
      per_d = 12'd0;
    end else begin
      per_d = (per_q == CntMax) ? per_q : per_q + 12'd1;
    end

    per_good  = (per_q >= PerLo) && (per_q <= PerHi);
    good_sync = sync_ok_q && per_good;
    // Once locked, only on-period syncs may pull the flywheel.
    align     = sync_ok_q && ((fsm_q != StLocked) || per_good);
    wrap      = (count_q == LineLast);

    if (align) begin
      count_d = SyncLoad;
    end else if (wrap) begin
      count_d = 12'd0;
    end else begin
      count_d = count_q + 12'd1;
    end

    fsm_d  = fsm_q;
    good_d = good_q;
    miss_d = miss_q;
    seen_d = seen_q;

    unique case (fsm_q)
      StSearch: begin
        if (sync_ok_q) begin
          fsm_d  = StAcquire;
          good_d = 4'd0;
        end
      end
      StAcquire: begin
        if (sync_ok_q) begin
          if (per_good) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 >= LockLines) begin
              fsm_d  = StLocked;
              miss_d = 4'd0;
              // The locking sync covers the line it sits in.
              seen_d = 1'b1;
            end
          end else begin
            good_d = 4'd0;
          end
        end else if (per_q > PerHi) begin
          fsm_d = StSearch;
        end
      end
      StLocked: begin
        // Miss check looks at the flag as it stood before this clock's sync.
        if (wrap) begin
          seen_d = 1'b0;
          if (!seen_q) begin
            miss_d = miss_q + 4'd1;
          end
        end
        if (good_sync) begin
          miss_d = 4'd0;
          seen_d = 1'b1;
        end
        if (miss_d >= MissLines) begin
          fsm_d = StSearch;
        end
      end
      default: begin
        fsm_d = StSearch;
      end
    endcase
  end

  // Registered outputs; state is decoded from the next count so it lines up
  // with the counter value of the same cycle.
  always_comb begin
    locked_d     = (fsm_d == StLocked);
    state_d      = locked_d ? decode_phase(count_d) : PhPorch;
    line_start_d = locked_q && wrap && !align;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q        <= StSearch;
      sync_low_q   <= 1'b0;
      pw_q         <= 12'd0;
      per_q        <= 12'd0;
      count_q      <= 12'd0;
      good_q       <= 4'd0;
      miss_q       <= 4'd0;
      seen_q       <= 1'b0;
      sync_ok_q    <= 1'b0;
      locked_q     <= 1'b0;
      line_start_q <= 1'b0;
      state_q      <= PhPorch;
    end else begin
      fsm_q        <= fsm_d;
      sync_low_q   <= sync_low_d;
      pw_q         <= pw_d;
      per_q        <= per_d;
      count_q      <= count_d;
      good_q       <= good_d;
      miss_q       <= miss_d;
      seen_q       <= seen_d;
      sync_ok_q    <= sync_ok_d;
      locked_q     <= locked_d;
      line_start_q <= line_start_d;
      state_q      <= state_d;
    end
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign line_start = line_start_q;
  assign sync_ok    = sync_ok_q;

endmodule

// File: tb/tb_sync_decoder.sv
// -----------------------------------------------------------------------------
// tb_sync_decoder
//
// Directed bench for sync_decoder: table-driven phase and width vectors plus
// hand-written multi-line sequences for lock, flywheel, loss and reset.
// -----------------------------------------------------------------------------
module tb_sync_decoder;

  localparam int LineLen = 3176;
  localparam int SyncW   = 235;

  logic       clk;
  logic       reset;
  logic [7:0] sample;
  logic [2:0] state;
  logic       locked;
  logic       line_start;
  logic       sync_ok;

  sync_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .sample     (sample),
    .state      (state),
    .locked     (locked),
    .line_start (line_start),
    .sync_ok    (sync_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         off;
    logic [2:0] st;
  } st_vec_t;

  typedef struct {
    int width;
    int pulses;
  } w_vec_t;

  int checks = 0;
  int errors = 0;

  int   cyc        = 0;
  int   sok_n      = 0;
  int   ls_n       = 0;
  int   ls_cyc     = 0;
  int   gap_bad    = 0;
  int   fall_cyc   = -1;
  int   locked_cyc = 0;
  int   unl_cyc    = 0;
  logic prev_sok    = 1'b0;
  logic prev_locked = 1'b0;
  logic       lk_after [16];
  logic [2:0] cap [LineLen];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // One clock: wait for the falling edge and log DUT outputs.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (prev_sok && sok_n < 16) lk_after[sok_n] = locked;
    if (sync_ok) sok_n++;
    prev_sok = sync_ok;
    if (line_start) begin
      if (ls_n > 0 && (cyc - ls_cyc) != LineLen) gap_bad++;
      ls_n++;
      ls_cyc = cyc;
    end
    if ((cyc - ls_cyc) < LineLen) cap[cyc - ls_cyc] = state;
    if (prev_locked && !locked) fall_cyc = cyc;
    prev_locked = locked;
    if (locked) locked_cyc++;
    else unl_cyc++;
  endtask

  task automatic drive_line(input int width, input int len);
    for (int i = 0; i < len; i++) begin
      sample = (i < width) ? 8'd0 : 8'd128;
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  st_vec_t st_tab [12];
  w_vec_t  w_tab  [6];

  initial begin
    int l0;
    int s0;

    st_tab[0]  = '{0,    3'd1};
    st_tab[1]  = '{74,   3'd1};
    st_tab[2]  = '{75,   3'd0};
    st_tab[3]  = '{309,  3'd0};
    st_tab[4]  = '{310,  3'd1};
    st_tab[5]  = '{339,  3'd1};
    st_tab[6]  = '{340,  3'd2};
    st_tab[7]  = '{464,  3'd2};
    st_tab[8]  = '{465,  3'd1};
    st_tab[9]  = '{544,  3'd1};
    st_tab[10] = '{545,  3'd3};
    st_tab[11] = '{3175, 3'd3};

    w_tab[0] = '{150, 0};
    w_tab[1] = '{199, 0};
    w_tab[2] = '{200, 1};
    w_tab[3] = '{270, 1};
    w_tab[4] = '{271, 0};
    w_tab[5] = '{300, 0};

    // Reset state.
    reset  = 1'b0;
    sample = 8'd128;
    repeat (3) tick();
    check("reset_state", state, 3'd1);
    check("reset_locked", locked, 1'b0);
    check("reset_line_start", line_start, 1'b0);
    check("reset_sync_ok", sync_ok, 1'b0);
    reset = 1'b1;
    tick();

    // Ideal line train: lock on the 5th qualified sync.
    sok_n   = 0;
    ls_n    = 0;
    gap_bad = 0;
    repeat (7) drive_line(SyncW, LineLen);
    check("ideal_locked_after_4th", lk_after[4], 1'b0);
    check("ideal_locked_after_5th", lk_after[5], 1'b1);
    check("ideal_sync_ok_count", sok_n, 7);
    check("ideal_line_start_count", ls_n, 3);
    check("ideal_line_start_gap", gap_bad, 0);
    check("ideal_locked", locked, 1'b1);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("phase_at_count_%0d", st_tab[i].off), cap[st_tab[i].off], st_tab[i].st);
    end

    // Reset mid-activeVideo aborts asynchronously, then relock.
    sample = 8'd128;
    repeat (1000) tick();
    check("pre_reset_active", state, 3'd3);
    #2 reset = 1'b0;
    #1;
    check("async_reset_state", state, 3'd1);
    check("async_reset_locked", locked, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    sok_n = 0;
    ls_n  = 0;
    repeat (6) drive_line(SyncW, LineLen);
    check("relock_after_4th", lk_after[4], 1'b0);
    check("relock_after_5th", lk_after[5], 1'b1);
    check("relock_locked", locked, 1'b1);

    // One sync shifted +20: flywheel holds, no realignment.
    ls_n    = 0;
    gap_bad = 0;
    unl_cyc = 0;
    s0      = sok_n;
    drive_line(SyncW, LineLen + 20);
    drive_line(SyncW, LineLen - 20);
    drive_line(SyncW, LineLen);
    drive_line(SyncW, LineLen);
    check("shift_unlocked_cycles", unl_cyc, 0);
    check("shift_line_start_gap", gap_bad, 0);
    check("shift_line_start_count", ls_n, 4);
    check("shift_sync_ok_count", sok_n - s0, 4);

    // Syncs removed: lock drops at the 3rd wrap without a good sync.
    l0       = ls_cyc;
    fall_cyc = -1;
    sample   = 8'd128;
    for (int i = 0; i < 4 * LineLen && fall_cyc < 0; i++) tick();
    check("loss_fall_offset", fall_cyc - l0, 3 * LineLen);
    check("loss_state_at_fall", state, 3'd1);
    tick();
    check("loss_state_next", state, 3'd1);
    check("loss_locked_next", locked, 1'b0);

    // Period 3190, outside tolerance: never locks.
    locked_cyc = 0;
    s0         = sok_n;
    repeat (5) drive_line(SyncW, 3190);
    check("bad_period_locked_cycles", locked_cyc, 0);
    check("bad_period_sync_ok_count", sok_n - s0, 5);

    // Width qualification boundaries.
    for (int i = 0; i < 6; i++) begin
      s0 = sok_n;
      drive_line(w_tab[i].width, 600);
      check($sformatf("width_%0d_pulses", w_tab[i].width), sok_n - s0, w_tab[i].pulses);
      check($sformatf("width_%0d_locked", w_tab[i].width), locked, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
